// File: rtl/frame_bank_sched.sv
// Triple-buffer bank scheduler between the camera capture writer and the display reader.
// Captured frames rotate through three banks of one frame memory; the reader only ever gets completed frames.
module frame_bank_sched #(
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned MIN_PIX = 1000,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              capture_en,
  input  logic              vsync,
  input  logic              buff_wr,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [11:0]       data12,
  input  logic              rd_frame_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              mem_we,
  output logic [ADDR_W+1:0] mem_waddr,
  output logic [11:0]       mem_wdata,
  output logic [ADDR_W+1:0] mem_raddr,
  output logic [1:0]        rd_bank,
  output logic              frame_ready,
  output logic              capturing,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  repeat_cnt,
  output logic [CNT_W-1:0]  abort_cnt
);

  localparam int unsigned PIX_W = ADDR_W + 1;

  typedef enum logic [1:0] {W_IDLE, W_CAPT, W_COMMIT} wstate_e;

  wstate_e           r_state;
  logic              r_vsync_d;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic [1:0]        r_wr_bank;
  logic [1:0]        r_rdy_bank;
  logic [1:0]        r_rd_bank;
  logic              r_frame_ready;
  logic              r_mem_we;
  logic [ADDR_W+1:0] r_mem_waddr;
  logic [11:0]       r_mem_wdata;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [CNT_W-1:0]  r_repeat_cnt;
  logic [CNT_W-1:0]  r_abort_cnt;

  logic w_rise;
  logic w_fall;
  logic w_commit;
  logic w_abort;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign w_rise   = vsync & ~r_vsync_d;
  assign w_fall   = ~vsync & r_vsync_d;
  assign w_commit = (r_state == W_COMMIT) && (r_pix_cnt >= PIX_W'(MIN_PIX));
  assign w_abort  = (r_state == W_COMMIT) && (r_pix_cnt < PIX_W'(MIN_PIX));

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state       <= W_IDLE;
      r_vsync_d     <= 1'b0;
      r_pix_cnt     <= '0;
      r_wr_bank     <= 2'd0;
      r_rdy_bank    <= 2'd1;
      r_rd_bank     <= 2'd2;
      r_frame_ready <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_waddr   <= '0;
      r_mem_wdata   <= '0;
      r_drop_cnt    <= '0;
      r_repeat_cnt  <= '0;
      r_abort_cnt   <= '0;
    end else begin
      r_vsync_d <= vsync;
      r_mem_we  <= buff_wr && (r_state == W_CAPT);
      if (buff_wr && (r_state == W_CAPT)) begin
        r_mem_waddr <= {r_wr_bank, addr_wr};
        r_mem_wdata <= data12;
      end

      case (r_state)
        W_IDLE: begin
          if (w_rise && capture_en) begin
            r_state   <= W_CAPT;
            r_pix_cnt <= '0;
          end
        end
        W_CAPT: begin
          if (buff_wr && (r_pix_cnt != {PIX_W{1'b1}}))
            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
          if (w_fall)
            r_state <= W_COMMIT;
        end
        W_COMMIT: r_state <= W_IDLE;
        default:  r_state <= W_IDLE;
      endcase

      if (w_abort)
        r_abort_cnt <= sat_inc(r_abort_cnt);

      // A request landing on the commit cycle hands the fresh frame straight to the reader.
      if (w_commit && rd_frame_req) begin
        r_rd_bank     <= r_wr_bank;
        r_wr_bank     <= r_rd_bank;
        r_frame_ready <= 1'b0;
        if (r_frame_ready)
          r_drop_cnt <= sat_inc(r_drop_cnt);
      end else if (w_commit) begin
        r_wr_bank     <= r_rdy_bank;
        r_rdy_bank    <= r_wr_bank;
        r_frame_ready <= 1'b1;
        if (r_frame_ready)
          r_drop_cnt <= sat_inc(r_drop_cnt);
      end else if (rd_frame_req) begin
        if (r_frame_ready) begin
          r_rd_bank     <= r_rdy_bank;
          r_rdy_bank    <= r_rd_bank;
          r_frame_ready <= 1'b0;
        end else begin
          r_repeat_cnt <= sat_inc(r_repeat_cnt);
        end
      end
    end
  end

  assign mem_we      = r_mem_we;
  assign mem_waddr   = r_mem_waddr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_raddr   = {r_rd_bank, rd_addr};
  assign rd_bank     = r_rd_bank;
  assign frame_ready = r_frame_ready;
  assign capturing   = (r_state == W_CAPT);
  assign drop_cnt    = r_drop_cnt;
  assign repeat_cnt  = r_repeat_cnt;
  assign abort_cnt   = r_abort_cnt;

endmodule

// File: tb/tb_frame_bank_sched.sv
// Bench for frame_bank_sched: write-path scoreboard plus directed bank/counter status checks.
module tb_frame_bank_sched;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned CNT_W  = 8;

  logic              pclk;
  logic              rst;
  logic              capture_en;
  logic              vsync;
  logic              buff_wr;
  logic [ADDR_W-1:0] addr_wr;
  logic [11:0]       data12;
  logic              rd_frame_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              mem_we;
  logic [ADDR_W+1:0] mem_waddr;
  logic [11:0]       mem_wdata;
  logic [ADDR_W+1:0] mem_raddr;
  logic [1:0]        rd_bank;
  logic              frame_ready;
  logic              capturing;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  repeat_cnt;
  logic [CNT_W-1:0]  abort_cnt;

  frame_bank_sched #(.ADDR_W(ADDR_W), .MIN_PIX(1000), .CNT_W(CNT_W)) dut (
    .pclk(pclk), .rst(rst), .capture_en(capture_en), .vsync(vsync),
    .buff_wr(buff_wr), .addr_wr(addr_wr), .data12(data12),
    .rd_frame_req(rd_frame_req), .rd_addr(rd_addr),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .rd_bank(rd_bank), .frame_ready(frame_ready),
    .capturing(capturing), .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt),
    .abort_cnt(abort_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [ADDR_W+1:0] addr;
    logic [11:0]       data;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic status(input string tag, input logic [1:0] rb, input logic rdy,
                        input int drop, input int rep, input int abrt);
    chk($sformatf("%s_rd_bank", tag), 32'(rd_bank), 32'(rb));
    chk($sformatf("%s_raddr", tag), 32'(mem_raddr), 32'({rb, rd_addr}));
    chk($sformatf("%s_frame_ready", tag), 32'(frame_ready), 32'(rdy));
    chk($sformatf("%s_drop", tag), 32'(drop_cnt), 32'(drop));
    chk($sformatf("%s_repeat", tag), 32'(repeat_cnt), 32'(rep));
    chk($sformatf("%s_abort", tag), 32'(abort_cnt), 32'(abrt));
  endtask

  task automatic req_pulse;
    tick;
    rd_frame_req = 1'b1;
    tick;
    rd_frame_req = 1'b0;
  endtask

  // One frame: rise cycle, n strobes, fall cycle, commit cycle (optional request), idle cycle.
  task automatic frame(input int n, input bit expect_wr, input logic [1:0] bank,
                       input bit req_at_commit, input bit en_drop_mid);
    tick;
    vsync = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick;
      buff_wr = 1'b1;
      addr_wr = ADDR_W'(i);
      data12  = 12'(i * 3 + int'(bank));
      if (expect_wr) sbq.push_back('{cyc + 1, {bank, ADDR_W'(i)}, data12});
      if (i == 0) chk("capturing_in_frame", 32'(capturing), 32'(expect_wr));
      if (en_drop_mid && i == n / 2) capture_en = 1'b0;
    end
    tick;
    buff_wr = 1'b0;
    vsync   = 1'b0;
    tick;
    rd_frame_req = req_at_commit;
    tick;
    rd_frame_req = 1'b0;
    if (en_drop_mid) capture_en = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    capture_en   = 1'b1;
    vsync        = 1'b0;
    buff_wr      = 1'b0;
    addr_wr      = '0;
    data12       = '0;
    rd_frame_req = 1'b0;
    rd_addr      = ADDR_W'(5);

    fork
      forever begin
        @(negedge pclk);
        if (mem_we) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=addr %0h data %0h required=no write", mem_waddr, mem_wdata);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            chk("wr_addr", 32'(mem_waddr), 32'(e.addr));
            chk("wr_data", 32'(mem_wdata), 32'(e.data));
          end
        end
      end
    join_none

    repeat (2) tick;
    rst = 1'b0;
    status("reset", 2'd2, 1'b0, 0, 0, 0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_waddr", 32'(mem_waddr), 32'd0);
    chk("reset_wdata", 32'(mem_wdata), 32'd0);
    chk("reset_capturing", 32'(capturing), 32'd0);

    frame(1200, 1'b1, 2'd0, 1'b0, 1'b0);
    status("f1", 2'd2, 1'b1, 0, 0, 0);
    req_pulse;
    status("req1", 2'd0, 1'b0, 0, 0, 0);
    req_pulse;
    status("req2", 2'd0, 1'b0, 0, 1, 0);

    // Two commits without a read: the first one is dropped.
    frame(1200, 1'b1, 2'd1, 1'b0, 1'b0);
    frame(1200, 1'b1, 2'd2, 1'b0, 1'b0);
    status("two", 2'd0, 1'b1, 1, 1, 0);
    req_pulse;
    status("req3", 2'd2, 1'b0, 1, 1, 0);

    frame(500, 1'b1, 2'd1, 1'b0, 1'b0);
    status("abort500", 2'd2, 1'b0, 1, 1, 1);
    frame(1000, 1'b1, 2'd1, 1'b1, 1'b0);
    status("simul", 2'd1, 1'b0, 1, 1, 1);
    frame(999, 1'b1, 2'd2, 1'b0, 1'b0);
    status("abort999", 2'd1, 1'b0, 1, 1, 2);
    frame(1000, 1'b1, 2'd2, 1'b0, 1'b0);
    status("commit1000", 2'd1, 1'b1, 1, 1, 2);
    req_pulse;
    status("req4", 2'd2, 1'b0, 1, 1, 2);

    // Asynchronous reset in the middle of a frame into bank 0.
    tick;
    vsync = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick;
      buff_wr = 1'b1;
      addr_wr = ADDR_W'(i);
      data12  = 12'(i + 7);
      sbq.push_back('{cyc + 1, {2'd0, ADDR_W'(i)}, data12});
    end
    tick;
    buff_wr = 1'b0;
    #6;
    rst   = 1'b1;
    vsync = 1'b0;
    #1;
    status("rst_mid", 2'd2, 1'b0, 0, 0, 0);
    chk("rst_mid_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mid_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_mid_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_mid_capturing", 32'(capturing), 32'd0);
    chk("rst_mid_sb_drained", 32'(sbq.size()), 32'd0);
    tick;
    rst = 1'b0;

    frame(1200, 1'b1, 2'd0, 1'b0, 1'b0);
    status("post_rst", 2'd2, 1'b1, 0, 0, 0);

    capture_en = 1'b0;
    frame(1200, 1'b0, 2'd1, 1'b0, 1'b0);
    capture_en = 1'b1;
    status("cap_off", 2'd2, 1'b1, 0, 0, 0);

    frame(1200, 1'b1, 2'd1, 1'b0, 1'b1);
    status("en_mid", 2'd2, 1'b1, 1, 0, 0);

    // First request consumes the frame; the other 299 saturate repeat_cnt.
    repeat (300) req_pulse;
    status("sat", 2'd1, 1'b0, 1, 255, 0);

    repeat (3) tick;
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
